keypad_event_debouncer: RTL and testbench
=========================================

# keypad_event_debouncer

Parametrised keypad debouncer that sits between the keypad decoder and the display/control logic. It generalises press-only debouncing to a full press/hold/release life cycle. It runs separate press and release debounce windows, rejects multi-key (ghost) combinations, and emits one-cycle press/release event strobes alongside the held-level outputs. An optional typematic auto-repeat generates periodic repeat strobes while a key stays held.

## Interface
- CODE_W, 4: width of key code; code 0 means "no/invalid key".
- PRESS_CYCLES, 60000: stable cycles required to accept a press (~20 ms at 3 MHz); legal range ≥ 1.
- RELEASE_CYCLES, 30000: stable-absent cycles required to accept a release; legal range ≥ 1.
- REPEAT_DELAY, 1500000: cycles from press acceptance to the first repeat strobe (KEYPAD_REPEAT_EN only).
- REPEAT_PERIOD, 300000: cycles between subsequent repeat strobes (KEYPAD_REPEAT_EN only).
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- key_code  input  CODE_W  decoded key code from the decoder.
- key_detected  input  1  scanner reports at least one key down.
- multi_key  input  1  scanner reports more than one key down (ghost risk).
- key_valid  output  1  level, high while a debounced key is held.
- debounced_key  output  CODE_W  latched code while key_valid is high, else 0.
- press_pulse  output  1  one-cycle strobe on press acceptance.
- release_pulse  output  1  one-cycle strobe on release acceptance.
- repeat_pulse  output  1  one-cycle typematic strobe; tied 0 without the macro.

## Operation
- Sample is "good" when key_detected=1, multi_key=0 and key_code≠0. A sample "matches" when it is good and key_code equals latched_key.
- States (enum in the package):
  - IDLE → PRESS_DB on a good sample; latch key_code; cnt=0.
  - PRESS_DB:
    - Sample not good → IDLE, with no event.
    - Good sample with a different code → re-latch the new code; cnt=0; stay in PRESS_DB.
    - Matching sample with cnt==PRESS_CYCLES-1 → HELD; press_pulse next cycle.
    - Otherwise cnt+1.
  - HELD:
    - Matching sample → stay.
    - Any non-matching sample (release, ghost, or different code) → RELEASE_DB; cnt=0.
  - RELEASE_DB:
    - Matching sample → HELD, with no events; the repeat timer is not reset.
    - Non-matching sample with cnt==RELEASE_CYCLES-1 → IDLE; release_pulse.
    - Otherwise cnt+1.
  - An illegal state encoding → IDLE with all outputs 0.
- key_valid=1 and debounced_key=latched_key in HELD and RELEASE_DB; both are 0 in IDLE and PRESS_DB.
- A different key pressed while one is held produces exactly one release of the old key. The new key then needs a fresh press debounce starting from IDLE.
- Counter width is $clog2(max(PRESS_CYCLES,RELEASE_CYCLES)+1). Counters saturate and never wrap.

## Timing
- Reset values: state=IDLE; cnt=0; latched_key=0. All outputs 0.
- All outputs decode from registers. There is no combinational path from any input to any output.
- Entry edge E (IDLE→PRESS_DB) followed by continuously matching samples:
  - HELD is entered at edge E+PRESS_CYCLES.
  - key_valid and press_pulse go high in the following cycle.
  - press_pulse lasts exactly 1 cycle.
- release_pulse is high for 1 cycle. It coincides with the first cycle in which key_valid=0.
- press_pulse, release_pulse and repeat_pulse are mutually exclusive in any cycle.
- Asserting rst_n low in any state clears everything immediately. No pulse is emitted afterwards.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - A repeat timer starts at press acceptance.
  - repeat_pulse fires REPEAT_DELAY cycles after press_pulse, then every REPEAT_PERIOD cycles.
  - The timer runs only while the state is HELD or RELEASE_DB.
  - The timer is cleared on entry to IDLE.
  - No repeat pulse is issued in the cycle release_pulse fires.
- KEYPAD_REPEAT_EN undefined:
  - No repeat logic is built.
  - repeat_pulse is tied 0.
  - The REPEAT_* parameters are ignored.

## Structure
- keypad_pkg holds:
  - the kd_state_t enum (IDLE, PRESS_DB, HELD, RELEASE_DB);
  - the NO_KEY code constant (0);
  - default timing localparams.
- One sub-module, kd_cycle_timer, is a parametrised saturating cycle counter with clear, enable and terminal-count output. It is instantiated once for the debounce window and once for repeat under the macro.

## Test plan
- Parameters for all scenarios: PRESS_CYCLES=4, RELEASE_CYCLES=3, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Code 5 held for 20 cycles from edge E:
  - press_pulse is high only in cycle E+5.
  - key_valid=1 and debounced_key=5 from E+5 onward.
- Code 5 for 2 cycles, then 0:
  - No pulse occurs.
  - key_valid stays 0.
- Code 5 accepted, then key released for 2 cycles, then 5 again:
  - No release_pulse.
  - key_valid stays 1 throughout.
- Code 5 held, then multi_key=1 for 5 cycles:
  - Exactly one release_pulse occurs, 3 cycles after the fault starts.
  - debounced_key then reads 0.
- KEYPAD_REPEAT_EN defined, code 9 held for 30 cycles after acceptance:
  - repeat_pulse fires at acceptance+10, +15, +20 and +25.
  - Without the macro, repeat_pulse is always 0.
- rst_n asserted low mid-PRESS_DB and mid-HELD:
  - All outputs are 0 immediately.
  - No release_pulse follows reset deassertion.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and default timing for the keypad event debouncer.
// The optional typematic auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kd_state_t;

  localparam int NO_KEY = 0;

  // Defaults assume a 3 MHz clock: 20 ms press, 10 ms release, 0.5 s delay, 0.1 s period.
  localparam int DEF_PRESS_CYCLES   = 60000;
  localparam int DEF_RELEASE_CYCLES = 30000;
  localparam int DEF_REPEAT_DELAY   = 1500000;
  localparam int DEF_REPEAT_PERIOD  = 300000;

  function automatic int kd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kd_cycle_timer.sv
// Saturating cycle counter with synchronous clear (priority over enable) and a
// terminal-count flag that is high while the count equals limit_i.
module kd_cycle_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: next-state logic assigns its output first on every path, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/keypad_event_debouncer.sv
// Keypad debouncer with press/hold/release life cycle, ghost rejection and event strobes.
// Define KEYPAD_REPEAT_EN to build the typematic auto-repeat generator.
module keypad_event_debouncer
  import keypad_pkg::*;
#(
  parameter int CODE_W         = 4,
  parameter int PRESS_CYCLES   = DEF_PRESS_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_detected,
  input  logic              multi_key,
  output logic              key_valid,
  output logic [CODE_W-1:0] debounced_key,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              repeat_pulse
);

  localparam int CNT_W = $clog2(kd_max(PRESS_CYCLES, RELEASE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

  kd_state_t         state_q, state_d;
  logic [CODE_W-1:0] latched_q, latched_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              good, match, held;
  logic              db_clr, db_en, db_tc;
  logic [CNT_W-1:0]  db_limit;

  assign good     = key_detected && !multi_key && (key_code != CODE_W'(NO_KEY));
  assign match    = good && (key_code == latched_q);
  assign held     = (state_q == HELD) || (state_q == RELEASE_DB);
  assign db_limit = (state_q == RELEASE_DB) ? RELEASE_LAST : PRESS_LAST;

  kd_cycle_timer #(.WIDTH(CNT_W)) u_db_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (db_clr),
    .en_i    (db_en),
    .limit_i (db_limit),
    .tc_o    (db_tc)
  );

  // The window counter only advances on the "keep waiting" paths; every transition restarts it.
  always_comb begin
    state_d   = state_q;
    latched_d = latched_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    db_clr    = 1'b1;
    db_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (good) begin
          state_d   = PRESS_DB;
          latched_d = key_code;
        end
      end
      PRESS_DB: begin
        if (!good) begin
          state_d   = IDLE;
          latched_d = CODE_W'(NO_KEY);
        end else if (key_code != latched_q) begin
          latched_d = key_code;
        end else if (db_tc) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          db_clr = 1'b0;
          db_en  = 1'b1;
        end
      end
      HELD: begin
        if (!match) state_d = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (match) begin
          state_d = HELD;
        end else if (db_tc) begin
          state_d   = IDLE;
          release_d = 1'b1;
          latched_d = CODE_W'(NO_KEY);
        end else begin
          db_clr = 1'b0;
          db_en  = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        latched_d = CODE_W'(NO_KEY);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      latched_q <= CODE_W'(NO_KEY);
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      latched_q <= latched_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_valid     = held;
  assign debounced_key = held ? latched_q : CODE_W'(NO_KEY);
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(kd_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic rpt_tc, rpt_fire, rpt_clr;
  logic rpt_first_q, rpt_first_d;
  logic repeat_q;

  // Timer runs through release debounce; a strobe is withheld on the release edge itself.
  assign rpt_fire = held && rpt_tc && !release_d;
  assign rpt_clr  = !held || rpt_fire || release_d;

  always_comb begin
    rpt_first_d = rpt_first_q;
    if (!held || release_d) begin
      rpt_first_d = 1'b0;
    end else if (rpt_fire) begin
      rpt_first_d = 1'b1;
    end
  end

  kd_cycle_timer #(.WIDTH(RPT_W)) u_rpt_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (rpt_clr),
    .en_i    (held),
    .limit_i (rpt_first_q ? PERIOD_LAST : DELAY_LAST),
    .tc_o    (rpt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_first_q <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      rpt_first_q <= rpt_first_d;
      repeat_q    <= rpt_fire;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_event_debouncer.sv
// Directed, table-driven bench for keypad_event_debouncer (PRESS=4, RELEASE=3, DELAY=10, PERIOD=5).
// Repeat expectations follow KEYPAD_REPEAT_EN; without it repeat_pulse must stay 0.
module tb_keypad_event_debouncer;

`ifdef KEYPAD_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_detected = 1'b0;
  logic       multi_key = 1'b0;
  logic       key_valid;
  logic [3:0] debounced_key;
  logic       press_pulse, release_pulse, repeat_pulse;

  always #5 clk = ~clk;

  keypad_event_debouncer #(
    .CODE_W         (4),
    .PRESS_CYCLES   (4),
    .RELEASE_CYCLES (3),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_code      (key_code),
    .key_detected  (key_detected),
    .multi_key     (multi_key),
    .key_valid     (key_valid),
    .debounced_key (debounced_key),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  typedef struct {
    logic       det;
    logic       multi;
    logic [3:0] code;
    logic       kv;
    logic [3:0] dk;
    logic       pp;
    logic       rp;
    logic       rpt;
  } vec_t;

  vec_t vecs[$];
  int   since_acc = -1;
  int   n_checks  = 0;
  int   n_fail    = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Repeat strobes land DELAY cycles after acceptance, then every PERIOD, while the key is valid.
  function automatic bit rpt_hit(input int k);
    return RPT_ON && (k >= 10) && (((k - 10) % 5) == 0);
  endfunction

  function automatic void add(input logic det, input logic multi, input logic [3:0] code,
                              input logic kv, input logic [3:0] dk, input logic pp, input logic rp);
    vec_t v;
    logic r;
    r = 1'b0;
    if (pp) begin
      since_acc = 0;
    end else if (rp) begin
      since_acc = -1;
    end else if (kv) begin
      since_acc++;
      r = rpt_hit(since_acc);
    end
    v = '{det, multi, code, kv, dk, pp, rp, r};
    vecs.push_back(v);
  endfunction

  function automatic void idle_rows(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endfunction

  // Entry sample plus three more matching samples, acceptance on the fifth.
  function automatic void press_key(input logic [3:0] c);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, c, 1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, c, 1'b1, c, 1'b1, 1'b0);
  endfunction

  function automatic void hold_key(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, c, 1'b1, c, 1'b0, 1'b0);
  endfunction

  function automatic void release_key(input logic [3:0] c);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4'd0, 1'b1, c, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
  endfunction

  task automatic drive(input logic det, input logic multi, input logic [3:0] code);
    key_detected = det;
    multi_key    = multi;
    key_code     = code;
  endtask

  task automatic check_all_zero(input string name, input int idx);
    check({name, "_kv"},  idx, 32'(key_valid),     32'd0);
    check({name, "_dk"},  idx, 32'(debounced_key), 32'd0);
    check({name, "_pp"},  idx, 32'(press_pulse),   32'd0);
    check({name, "_rp"},  idx, 32'(release_pulse), 32'd0);
    check({name, "_rpt"}, idx, 32'(repeat_pulse),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Stimulus table
    idle_rows(2);
    press_key(4'd5); hold_key(4'd5, 15); release_key(4'd5); idle_rows(1);          // clean press/hold/release
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    idle_rows(3);                                                                  // too-short bounce
    press_key(4'd5); hold_key(4'd5, 2);
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    hold_key(4'd5, 2); release_key(4'd5); idle_rows(1);                            // release glitch
    press_key(4'd5); hold_key(4'd5, 2);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0);
    add(1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0); idle_rows(2);                   // ghost while held
    press_key(4'd5); hold_key(4'd5, 2);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 4'd7, 1'b1, 4'd5, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1);
    press_key(4'd7); hold_key(4'd7, 2); release_key(4'd7); idle_rows(1);           // key change while held
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    press_key(4'd6); release_key(4'd6); idle_rows(1);                              // re-latch in press window
    press_key(4'd9); hold_key(4'd9, 28); release_key(4'd9); idle_rows(1);          // typematic run

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.det, v.multi, v.code);
      @(posedge clk);
      #1;
      check("key_valid",     i, 32'(key_valid),     32'(v.kv));
      check("debounced_key", i, 32'(debounced_key), 32'(v.dk));
      check("press_pulse",   i, 32'(press_pulse),   32'(v.pp));
      check("release_pulse", i, 32'(release_pulse), 32'(v.rp));
      check("repeat_pulse",  i, 32'(repeat_pulse),  32'(v.rpt));
    end

    // Reset in the middle of press debounce
    drive(1'b1, 1'b0, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_press_db", 0);
    drive(1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("after_rst_press_db", i);
    end

    // Reset while held, right as press_pulse is high
    drive(1'b1, 1'b0, 4'd5);
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_pp", 0, 32'(press_pulse),   32'd1);
    check("pre_rst_dk", 0, 32'(debounced_key), 32'd5);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_held", 0);
    drive(1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("after_rst_held", i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
